// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the two-road intersection controller.
// Lamp vectors are one-hot {red, yellow, green}; pedestrian vectors are
// {stop, clear, walk}. PED_DARK is the off half of the clearance flash.
package traffic_pkg;

  localparam int unsigned LAMP_W = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    R1_GREEN  = 3'd1,
    R1_YELLOW = 3'd2,
    ALL_RED1  = 3'd3,
    R2_GREEN  = 3'd4,
    R2_YELLOW = 3'd5,
    ALL_RED2  = 3'd6
  } tc_state_t;

  localparam logic [LAMP_W-1:0] LIGHT_RED    = 3'b100;
  localparam logic [LAMP_W-1:0] LIGHT_YELLOW = 3'b010;
  localparam logic [LAMP_W-1:0] LIGHT_GREEN  = 3'b001;

  localparam logic [LAMP_W-1:0] PED_STOP  = 3'b100;
  localparam logic [LAMP_W-1:0] PED_CLEAR = 3'b010;
  localparam logic [LAMP_W-1:0] PED_WALK  = 3'b001;
  localparam logic [LAMP_W-1:0] PED_DARK  = 3'b000;

  // Full set of lamp drives, registered as one word.
  typedef struct packed {
    logic [LAMP_W-1:0] road1;
    logic [LAMP_W-1:0] road2;
    logic [LAMP_W-1:0] ped1;
    logic [LAMP_W-1:0] ped2;
  } tc_lamps_t;

endpackage

// File: rtl/traffic_controller_if.sv
// Lamp/enable bundle between the intersection controller and its surroundings.
//   enable    : run request (low parks the controller in all-red)
//   road1_out : road 1 lamps {red, yellow, green}
//   road2_out : road 2 lamps
//   ped1      : pedestrian signal parallel to road 1 {stop, clear, walk}
//   ped2      : pedestrian signal parallel to road 2
// master = controller side, slave = supervisor / lamp-driver side.
interface traffic_controller_if;
  logic       enable;
  logic [2:0] road1_out;
  logic [2:0] road2_out;
  logic [2:0] ped1;
  logic [2:0] ped2;

  modport master (input enable, output road1_out, road2_out, ped1, ped2);
  modport slave  (output enable, input road1_out, road2_out, ped1, ped2);
endinterface

// File: rtl/tc_phase_timer.sv
// Loadable down-counter timing each controller phase.
//   clk, rst_n : clock and asynchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase duration minus one
//   done       : count has reached zero (decode of the registered count)
module tc_phase_timer #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Count down and hold at zero until the next load.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_controller.sv
// Two-road intersection controller with pedestrian signals. A timed Moore
// FSM alternates right-of-way with an all-red clearance after each yellow;
// enable is only honoured at the end of an all-red interval so green and
// yellow always complete.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-high reset (name kept from the codebase)
//   bus   : traffic_controller_if.master (enable in; road/ped lamps out)
// Optional feature: define TRAFFIC_PED_FLASH_EN to flash the pedestrian
// clear signal (010/000 every FLASH_HALF_CYCLES) during yellow.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES      = 400,
  parameter int YELLOW_CYCLES     = 40,
  parameter int ALL_RED_CYCLES    = 20,
  parameter int FLASH_HALF_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_controller_if.master bus
);

  if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1 || ALL_RED_CYCLES < 1 ||
      FLASH_HALF_CYCLES < 1) begin : g_bad_param
    $error("traffic_controller: all cycle parameters must be >= 1");
  end

  localparam int MAX_GY = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int MAX_C  = (MAX_GY > ALL_RED_CYCLES) ? MAX_GY : ALL_RED_CYCLES;
  localparam int unsigned TW = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  tc_state_t     state, next_state;
  logic          load;
  logic [TW-1:0] load_val;
  logic          done;
  tc_lamps_t     lamps, lamps_c;
  logic [2:0]    ped_clear1_c, ped_clear2_c;

  tc_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

`ifdef TRAFFIC_PED_FLASH_EN
  localparam int unsigned FW = (FLASH_HALF_CYCLES > 1) ? $clog2(2 * FLASH_HALF_CYCLES) : 1;
  logic [FW-1:0] flash_cnt, flash_cnt_c;
  logic          next_yellow;

  // Position within the 2*FLASH_HALF_CYCLES flash period, restarted on yellow entry.
  always_comb begin
    flash_cnt_c = '0;
    next_yellow = (next_state == R1_YELLOW) || (next_state == R2_YELLOW);
    if (next_yellow && (next_state == state)) begin
      flash_cnt_c = (flash_cnt == FW'(2 * FLASH_HALF_CYCLES - 1)) ? '0 : flash_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) flash_cnt <= '0;
    else       flash_cnt <= flash_cnt_c;
  end

  assign ped_clear1_c = (flash_cnt_c < FW'(FLASH_HALF_CYCLES)) ? PED_CLEAR : PED_DARK;
  assign ped_clear2_c = ped_clear1_c;
`else
  assign ped_clear1_c = PED_CLEAR;
  assign ped_clear2_c = PED_CLEAR;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= next_state;
  end

  // Next state, timer reload and lamp decode of the upcoming state.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = '0;
    unique case (state)
      IDLE: if (bus.enable) begin
        next_state = R1_GREEN;  load = 1'b1; load_val = TW'(GREEN_CYCLES - 1);
      end
      R1_GREEN: if (done) begin
        next_state = R1_YELLOW; load = 1'b1; load_val = TW'(YELLOW_CYCLES - 1);
      end
      R1_YELLOW: if (done) begin
        next_state = ALL_RED1;  load = 1'b1; load_val = TW'(ALL_RED_CYCLES - 1);
      end
      ALL_RED1: if (done) begin
        if (bus.enable) begin
          next_state = R2_GREEN; load = 1'b1; load_val = TW'(GREEN_CYCLES - 1);
        end else begin
          next_state = IDLE;
        end
      end
      R2_GREEN: if (done) begin
        next_state = R2_YELLOW; load = 1'b1; load_val = TW'(YELLOW_CYCLES - 1);
      end
      R2_YELLOW: if (done) begin
        next_state = ALL_RED2;  load = 1'b1; load_val = TW'(ALL_RED_CYCLES - 1);
      end
      ALL_RED2: if (done) begin
        if (bus.enable) begin
          next_state = R1_GREEN; load = 1'b1; load_val = TW'(GREEN_CYCLES - 1);
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    lamps_c = '{road1: LIGHT_RED, road2: LIGHT_RED, ped1: PED_STOP, ped2: PED_STOP};
    unique case (next_state)
      R1_GREEN:  begin lamps_c.road1 = LIGHT_GREEN;  lamps_c.ped1 = PED_WALK;     end
      R1_YELLOW: begin lamps_c.road1 = LIGHT_YELLOW; lamps_c.ped1 = ped_clear1_c; end
      R2_GREEN:  begin lamps_c.road2 = LIGHT_GREEN;  lamps_c.ped2 = PED_WALK;     end
      R2_YELLOW: begin lamps_c.road2 = LIGHT_YELLOW; lamps_c.ped2 = ped_clear2_c; end
      default:   ;
    endcase
  end

  // Lamps registered alongside the state so they follow it in the same clock.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) lamps <= '{road1: LIGHT_RED, road2: LIGHT_RED, ped1: PED_STOP, ped2: PED_STOP};
    else       lamps <= lamps_c;
  end

  assign bus.road1_out = lamps.road1;
  assign bus.road2_out = lamps.road2;
  assign bus.ped1      = lamps.ped1;
  assign bus.ped2      = lamps.ped2;

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller with default timing parameters.
// Expected lamp words are queued per phase and popped one per clock.
module tb_traffic_controller;
  import traffic_pkg::*;

  localparam int G = 400;
  localparam int Y = 40;
  localparam int A = 20;
  localparam int F = 5;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  logic [11:0] exp_q[$];

  traffic_controller_if bus ();

  traffic_controller #(
    .GREEN_CYCLES      (G),
    .YELLOW_CYCLES     (Y),
    .ALL_RED_CYCLES    (A),
    .FLASH_HALF_CYCLES (F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic [2:0] ped_clear(input int k);
`ifdef TRAFFIC_PED_FLASH_EN
    return (((k / F) % 2) == 0) ? 3'b010 : 3'b000;
`else
    return 3'b010;
`endif
  endfunction

  // Expected {road1, road2, ped1, ped2} for cycle k of a phase.
  function automatic logic [11:0] exp_word(input tc_state_t ph, input int k);
    case (ph)
      R1_GREEN:  return {3'b001, 3'b100, 3'b001, 3'b100};
      R1_YELLOW: return {3'b010, 3'b100, ped_clear(k), 3'b100};
      R2_GREEN:  return {3'b100, 3'b001, 3'b100, 3'b001};
      R2_YELLOW: return {3'b100, 3'b010, 3'b100, ped_clear(k)};
      default:   return {3'b100, 3'b100, 3'b100, 3'b100};
    endcase
  endfunction

  task automatic push_phase(input tc_state_t ph, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_word(ph, k));
  endtask

  task automatic check_now(input string tag, input logic [11:0] want);
    logic [11:0] obs;
    obs = {bus.road1_out, bus.road2_out, bus.ped1, bus.ped2};
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, cyc, obs, want);
    end
  endtask

  task automatic run_check(input int n);
    logic [11:0] want;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL scoreboard_empty cyc=%0d obs=0 exp=entry", cyc);
      end else begin
        want = exp_q.pop_front();
        check_now("lamps", want);
      end
    end
  endtask

  // Safety invariants, checked on every falling edge.
  always @(negedge clk) begin
    logic viol;
    viol = (bus.road1_out != 3'b100 && bus.road2_out != 3'b100) ||
           (bus.ped1 == 3'b001 && bus.road1_out != 3'b001) ||
           (bus.ped2 == 3'b001 && bus.road2_out != 3'b001);
    total++;
    assert (viol === 1'b0) else begin
      bad++;
      $error("FAIL invariant cyc=%0d obs=%b exp=0 r1=%b r2=%b p1=%b p2=%b",
             cyc, viol, bus.road1_out, bus.road2_out, bus.ped1, bus.ped2);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    bus.enable = 1'b0;
    rst_n = 1'b1;

    // Reset, then idle with enable low.
    #1;
    check_now("reset_async", {4{3'b100}});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push_phase(IDLE, 20);
    run_check(20);

    // Startup and a full cycle, then into road 2 green again.
    bus.enable = 1'b1;
    push_phase(R1_GREEN, G); push_phase(R1_YELLOW, Y); push_phase(ALL_RED1, A);
    push_phase(R2_GREEN, G); push_phase(R2_YELLOW, Y); push_phase(ALL_RED2, A);
    push_phase(R1_GREEN, G); push_phase(R1_YELLOW, Y); push_phase(ALL_RED1, A);
    push_phase(R2_GREEN, 100);
    run_check(2 * (G + Y + A) + G + Y + A + 100);

    // Drop enable 100 clocks into road 2 green: finish the cycle, then park.
    bus.enable = 1'b0;
    push_phase(R2_GREEN, G - 100); push_phase(R2_YELLOW, Y);
    push_phase(ALL_RED2, A); push_phase(IDLE, 20);
    run_check(G - 100 + Y + A + 20);

    // Reset asserted mid-yellow clears the lamps before the next edge.
    bus.enable = 1'b1;
    push_phase(R1_GREEN, G); push_phase(R1_YELLOW, 10);
    run_check(G + 10);
    rst_n = 1'b1;
    #1;
    check_now("reset_mid_yellow", {4{3'b100}});
    @(posedge clk);
    #1;
    cyc++;
    check_now("reset_held", {4{3'b100}});
    rst_n = 1'b0;

    // Restart from road 1 green, including the pedestrian clear pattern.
    push_phase(R1_GREEN, G); push_phase(R1_YELLOW, Y); push_phase(ALL_RED1, A);
    run_check(G + Y + A);

    total++;
    assert (exp_q.size() === 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover obs=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
